// File: rtl/io_port_if.sv
// Handshake bundle for io_port: external input stream, consumer side of the input
// FIFO, register-file output strobe and external output stream.
interface io_port_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic [WIDTH-1:0] ext_in_data;
    logic             ext_in_valid;
    logic             ext_in_ready;
    logic             input_valid;
    logic             input_ready;
    logic [WIDTH-1:0] in_data;
    logic             output_valid;
    logic [WIDTH-1:0] out_din;
    logic [WIDTH-1:0] ext_out_data;
    logic             ext_out_valid;
    logic             ext_out_ready;

    // io_port side
    modport slave (
        input  ext_in_data, ext_in_valid, input_ready, output_valid, out_din, ext_out_ready,
        output ext_in_ready, input_valid, in_data, ext_out_data, ext_out_valid
    );

    // environment side (sources, control unit, sink)
    modport master (
        output ext_in_data, ext_in_valid, input_ready, output_valid, out_din, ext_out_ready,
        input  ext_in_ready, input_valid, in_data, ext_out_data, ext_out_valid
    );
endinterface

// File: rtl/io_port.sv
// IO port: DEPTH-entry input FIFO plus a one-word output holding register.
// Optional sticky overflow flags with clear input when IO_OVERFLOW_FLAG_EN is defined.
module io_port #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
`ifdef IO_OVERFLOW_FLAG_EN
    output logic [1:0] overflow,
    input  logic       overflow_clr,
`endif
    io_port_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;
    typedef enum logic {OUT_EMPTY, OUT_HELD} out_state_t;

    ptr_t             wptr_q, wptr_d;
    ptr_t             rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full, empty, push, pop;

    out_state_t       out_state_q;
    logic [WIDTH-1:0] out_data_q;

    // Pointers carry one extra wrap bit so full and empty stay distinguishable.
    always_comb begin
        full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        empty  = (wptr_q == rptr_q);
        push   = bus.ext_in_valid && !full;
        pop    = bus.input_ready && !empty;
        wptr_d = push ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wptr_q[AW-1:0]] <= bus.ext_in_data;
        end
    end

    assign bus.ext_in_ready = !full;
    assign bus.input_valid  = !empty;
    assign bus.in_data      = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_state_q <= OUT_EMPTY;
            out_data_q  <= '0;
        end else begin
            case (out_state_q)
                OUT_EMPTY: begin
                    if (bus.output_valid) begin
                        out_data_q  <= bus.out_din;
                        out_state_q <= OUT_HELD;
                    end
                end
                OUT_HELD: begin
                    // A strobe arriving while the sink stalls is dropped.
                    if (bus.ext_out_ready) begin
                        if (bus.output_valid) begin
                            out_data_q <= bus.out_din;
                        end else begin
                            out_state_q <= OUT_EMPTY;
                        end
                    end
                end
                default: out_state_q <= OUT_EMPTY;
            endcase
        end
    end

    assign bus.ext_out_valid = (out_state_q == OUT_HELD);
    assign bus.ext_out_data  = out_data_q;

`ifdef IO_OVERFLOW_FLAG_EN
    logic       drop;
    logic [1:0] ovf_q, ovf_d;

    // Set events take priority over a same-cycle clear.
    always_comb begin
        drop  = (out_state_q == OUT_HELD) && bus.output_valid && !bus.ext_out_ready;
        ovf_d = overflow_clr ? 2'b00 : ovf_q;
        if (bus.ext_in_valid && full) begin
            ovf_d[0] = 1'b1;
        end
        if (drop) begin
            ovf_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`endif
endmodule

// File: tb/tb_io_port.sv
// Bench for io_port: directed scenarios plus random traffic against a queue-based model.
module tb_io_port;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    io_port_if #(.WIDTH(WIDTH)) bus ();
`ifdef IO_OVERFLOW_FLAG_EN
    logic [1:0] overflow;
    logic       overflow_clr;
`endif

    io_port #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef IO_OVERFLOW_FLAG_EN
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
`endif
        .bus          (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mq [$];
    bit               mheld;
    logic [WIDTH-1:0] mout;
    logic [1:0]       movf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("ext_in_ready", {31'b0, bus.ext_in_ready}, {31'b0, (mq.size() < DEPTH)});
        chk("input_valid", {31'b0, bus.input_valid}, {31'b0, (mq.size() > 0)});
        if (mq.size() > 0) chk("in_data", {16'b0, bus.in_data}, {16'b0, mq[0]});
        chk("ext_out_valid", {31'b0, bus.ext_out_valid}, {31'b0, mheld});
        chk("ext_out_data", {16'b0, bus.ext_out_data}, {16'b0, mout});
`ifdef IO_OVERFLOW_FLAG_EN
        chk("overflow", {30'b0, overflow}, {30'b0, movf});
`endif
    endtask

    // Advance one clock; the model is updated from the inputs as they stood at the edge.
    task automatic cycle();
        int               n;
        bit               full, push, pop, vin, ov, ordy, held0, clr, r;
        logic [WIDTH-1:0] din, od;
        n     = mq.size();
        full  = (n == DEPTH);
        vin   = bus.ext_in_valid;
        push  = vin && !full;
        pop   = bus.input_ready && (n > 0);
        din   = bus.ext_in_data;
        ov    = bus.output_valid;
        od    = bus.out_din;
        ordy  = bus.ext_out_ready;
        held0 = mheld;
        r     = rst;
        clr   = 1'b0;
`ifdef IO_OVERFLOW_FLAG_EN
        clr   = overflow_clr;
`endif
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            mheld = 1'b0;
            mout  = '0;
            movf  = '0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(din);
            if (!held0) begin
                if (ov) begin
                    mout  = od;
                    mheld = 1'b1;
                end
            end else if (ordy) begin
                if (ov) mout = od;
                else mheld = 1'b0;
            end
            if (clr) movf = '0;
            if (vin && full) movf[0] = 1'b1;
            if (held0 && !ordy && ov) movf[1] = 1'b1;
        end
        check_all();
    endtask

    task automatic idle_inputs();
        bus.ext_in_valid  = 1'b0;
        bus.ext_in_data   = '0;
        bus.input_ready   = 1'b0;
        bus.output_valid  = 1'b0;
        bus.out_din       = '0;
        bus.ext_out_ready = 1'b0;
`ifdef IO_OVERFLOW_FLAG_EN
        overflow_clr      = 1'b0;
`endif
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = w;
        cycle();
        bus.ext_in_valid = 1'b0;
    endtask

    initial begin
        mheld = 1'b0;
        mout  = '0;
        movf  = '0;
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("reset_ext_in_ready", {31'b0, bus.ext_in_ready}, 32'd1);
        chk("reset_ext_out_data", {16'b0, bus.ext_out_data}, 32'd0);

        // Ordered drain after filling with the consumer stalled
        push_word(16'h1111);
        push_word(16'h2222);
        push_word(16'h3333);
        bus.input_ready = 1'b1;
        chk("order_0", {16'b0, bus.in_data}, 32'h1111);
        cycle();
        chk("order_1", {16'b0, bus.in_data}, 32'h2222);
        cycle();
        chk("order_2", {16'b0, bus.in_data}, 32'h3333);
        cycle();
        chk("order_empty", {31'b0, bus.input_valid}, 32'd0);
        bus.input_ready = 1'b0;

        // Full FIFO rejects a persistent offer
        for (int i = 0; i < DEPTH; i++) push_word(16'hA000 + 16'(i));
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'h5555;
        cycle();
        cycle();
        chk("full_ready_low", {31'b0, bus.ext_in_ready}, 32'd0);
`ifdef IO_OVERFLOW_FLAG_EN
        chk("ovf0_set", {31'b0, overflow[0]}, 32'd1);
`endif
        bus.ext_in_valid = 1'b0;
        bus.input_ready  = 1'b1;
        for (int i = 0; i < DEPTH; i++) cycle();
        bus.input_ready = 1'b0;

        // Full FIFO with simultaneous push and pop: only the pop happens
        for (int i = 0; i < DEPTH; i++) push_word(16'hB000 + 16'(i));
        bus.ext_in_valid = 1'b1;
        bus.ext_in_data  = 16'hAAAA;
        bus.input_ready  = 1'b1;
        cycle();
        chk("fullpp_ready", {31'b0, bus.ext_in_ready}, 32'd1);
        chk("fullpp_head", {16'b0, bus.in_data}, 32'hB001);
        bus.input_ready = 1'b0;
        bus.ext_in_data = 16'hBBBB;
        cycle();
        chk("fullpp_refill", {31'b0, bus.ext_in_ready}, 32'd0);
        bus.ext_in_valid = 1'b0;
        bus.input_ready  = 1'b1;
        for (int i = 0; i < DEPTH; i++) cycle();
        bus.input_ready = 1'b0;
`ifdef IO_OVERFLOW_FLAG_EN
        overflow_clr = 1'b1;
        cycle();
        overflow_clr = 1'b0;
`endif

        // Output register: dropped strobe while stalled, then release
        bus.output_valid = 1'b1;
        bus.out_din      = 16'h00FF;
        cycle();
        bus.out_din = 16'h0F0F;
        cycle();
        bus.output_valid = 1'b0;
        chk("hold_data", {16'b0, bus.ext_out_data}, 32'h00FF);
`ifdef IO_OVERFLOW_FLAG_EN
        chk("ovf1_set", {31'b0, overflow[1]}, 32'd1);
`endif
        bus.ext_out_ready = 1'b1;
        cycle();
        chk("release_empty", {31'b0, bus.ext_out_valid}, 32'd0);
        bus.output_valid = 1'b1;
        bus.out_din      = 16'h00FF;
        cycle();
        bus.out_din = 16'h1234;
        cycle();
        chk("replace_data", {16'b0, bus.ext_out_data}, 32'h1234);
        chk("replace_valid", {31'b0, bus.ext_out_valid}, 32'd1);
        bus.output_valid  = 1'b0;
        bus.ext_out_ready = 1'b0;

        // Streaming push/pop pairs across pointer wrap, then reset mid-stream
        push_word(16'hC000);
        bus.ext_in_valid = 1'b1;
        bus.input_ready  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            bus.ext_in_data = 16'hC000 + 16'(i);
            cycle();
        end
        bus.input_ready = 1'b0;
        bus.ext_in_data = 16'hD000;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.ext_in_valid = 1'b0;
        chk("rst_input_valid", {31'b0, bus.input_valid}, 32'd0);
        chk("rst_out_valid", {31'b0, bus.ext_out_valid}, 32'd0);
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus.ext_in_valid  = ($urandom_range(0, 3) != 0);
            bus.ext_in_data   = 16'($urandom);
            bus.input_ready   = ($urandom_range(0, 2) != 0);
            bus.output_valid  = ($urandom_range(0, 2) == 0);
            bus.out_din       = 16'($urandom);
            bus.ext_out_ready = ($urandom_range(0, 1) != 0);
`ifdef IO_OVERFLOW_FLAG_EN
            overflow_clr      = ($urandom_range(0, 15) == 0);
`endif
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 1'b0;
        idle_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/io_port.md
IO_PORT -- requirements
Module: io_port

Interface
REQ-001 Parameter DEPTH, default 4, input FIFO entries; power of two, range 2..16.
REQ-002 Parameter WIDTH, default 16, data word width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ext_in_data  input  WIDTH  word from external source.
REQ-006 ext_in_valid  input  1  external source offers ext_in_data.
REQ-007 ext_in_ready  output  1  FIFO can accept a word (not full).
REQ-008 input_valid  output  1  to control unit: FIFO not empty, in_data valid.
REQ-009 input_ready  input  1  from control unit: consumer accepts in_data.
REQ-010 in_data  output  WIDTH  FIFO head word, to register-file input mux.
REQ-011 output_valid  input  1  from control unit: one-cycle OUT strobe.
REQ-012 out_din  input  WIDTH  register-file word to emit.
REQ-013 ext_out_data  output  WIDTH  held output word.
REQ-014 ext_out_valid  output  1  held output word pending.
REQ-015 ext_out_ready  input  1  external sink accepts ext_out_data.

Function
REQ-016 Push occurs when ext_in_valid && ext_in_ready; pop occurs when input_valid && input_ready.
REQ-017 ext_in_ready and input_valid are driven from registered occupancy only; neither depends combinationally on any input.
REQ-018 Full FIFO: ext_in_ready=0; a same-cycle pop does not enable a push that cycle.
REQ-019 Empty FIFO: input_valid=0; a same-cycle push is stored and visible on in_data the next cycle.
REQ-020 Simultaneous push and pop with occupancy between 1 and DEPTH-1: occupancy unchanged, order preserved.
REQ-021 in_data is the oldest stored word; it is stable while input_valid=1 and no pop occurs; its value is don't-care when empty.
REQ-022 Read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full = equal index with opposite MSB; empty = pointers equal.
REQ-023 Push-to-input_valid latency is 1 cycle.
REQ-024 Output holding register states: EMPTY (ext_out_valid=0) and HELD (ext_out_valid=1).
REQ-025 EMPTY + output_valid -> capture out_din, go to HELD next cycle.
REQ-026 HELD + ext_out_ready, no output_valid -> EMPTY.
REQ-027 HELD + ext_out_ready + output_valid -> capture out_din, stay HELD.
REQ-028 HELD + no ext_out_ready + output_valid -> strobe dropped, held word unchanged, stay HELD.
REQ-029 ext_out_data and ext_out_valid are stable while HELD and ext_out_ready=0.

Reset
REQ-030 While rst=1 at a clock edge: both pointers reset to 0, output register goes to EMPTY, ext_out_data resets to 0, and all pushes, pops and captures that cycle are ignored.
REQ-031 Outputs after reset: ext_in_ready=1, input_valid=0, ext_out_valid=0, ext_out_data=0; in_data is don't-care.
REQ-032 Reset mid-operation discards all FIFO contents and any held output word; nothing is replayed.

Configuration
REQ-033 Macro IO_OVERFLOW_FLAG_EN defined: add output port overflow (2 bits) and input port overflow_clr (1 bit).
REQ-034 overflow[0] sets when ext_in_valid=1 while the FIFO is full.
REQ-035 overflow[1] sets when a strobe is dropped per REQ-028.
REQ-036 Both overflow bits are sticky; overflow_clr=1 clears them; a set event in the same cycle as overflow_clr wins; reset value is 0.
REQ-037 Macro IO_OVERFLOW_FLAG_EN undefined: the overflow and overflow_clr ports are absent; all other behaviour is identical.

Verification
REQ-038 Push 0x1111, 0x2222, 0x3333 with input_ready=0, then input_ready=1 -> in_data 0x1111, 0x2222, 0x3333 on consecutive cycles, then input_valid=0.
REQ-039 Fill FIFO to DEPTH=4 and hold ext_in_valid with 0x5555 -> ext_in_ready=0; 0x5555 is not stored; overflow[0]=1 if enabled.
REQ-040 Full FIFO, one cycle with push 0xAAAA and pop together -> occupancy 3, 0xAAAA not stored; a push next cycle succeeds.
REQ-041 output_valid with out_din=0x00FF, ext_out_ready=0, then output_valid with 0x0F0F -> ext_out_data stays 0x00FF, overflow[1]=1 if enabled; ext_out_ready=1 -> EMPTY.
REQ-042 Run 10 push/pop pairs through DEPTH=4 -> pointer wrap, FIFO order preserved; rst pulse mid-stream -> input_valid=0 and ext_out_valid=0 on the next cycle.
